// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with skid buffer, redirect kill and halt detection.
// Define IF_FETCH_PERF_EN to add the saturating fetch_cnt delivered-instruction counter.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] inst_out,
    output logic        nop_out,
`ifdef IF_FETCH_PERF_EN
    output logic [15:0] fetch_cnt,
`endif
    output logic        halt
);
    typedef enum logic [1:0] {FETCH, SKID, KILL, HALT} state_t;
    state_t state;
    logic [15:0] pc, tgt, skid_pc, skid_inst, d_pc, d_inst;
    logic deliver, bubble;
    assign imem_req  = !rst && (state == FETCH || state == KILL);
    assign imem_addr = pc;
    assign halt      = state == HALT;
    always_comb begin
        deliver = !redirect && !stall && ((state == FETCH && imem_ack) || state == SKID);
        bubble  = redirect || (!stall && !deliver);
        d_pc    = state == SKID ? skid_pc : pc;
        d_inst  = state == SKID ? skid_inst : imem_rdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            tgt       <= RESET_PC;
            skid_pc   <= 16'h0000;
            skid_inst <= 16'h0000;
            pc_out    <= 16'h0000;
            inst_out  <= 16'h0000;
            nop_out   <= 1'b1;
        end else begin
            if (deliver) begin
                pc_out   <= d_pc;
                inst_out <= d_inst;
                nop_out  <= 1'b0;
            end else if (bubble) begin
                inst_out <= 16'h0000;
                nop_out  <= 1'b1;
            end
            if (redirect) begin
                tgt <= redirect_pc;
                // an unacked request cannot be aborted, so park in KILL until it drains
                if ((state == FETCH || state == KILL) && !imem_ack) begin
                    state <= KILL;
                end else begin
                    state <= FETCH;
                    pc    <= redirect_pc;
                end
            end else begin
                case (state)
                    FETCH: if (imem_ack) begin
                        pc <= pc + 16'd2;
                        if (stall) begin
                            skid_pc   <= pc;
                            skid_inst <= imem_rdata;
                            state     <= SKID;
                        end else begin
                            state <= d_inst[15:12] == HALT_OPCODE ? HALT : FETCH;
                        end
                    end
                    SKID: if (!stall) state <= d_inst[15:12] == HALT_OPCODE ? HALT : FETCH;
                    KILL: if (imem_ack) begin
                        pc    <= tgt;
                        state <= FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_cnt <= 16'h0000;
        else if (deliver && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, skid, redirect/kill, halt, PC wrap and reset abort.
module tb_if_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [15:0] redirect_pc = 16'h0000, imem_rdata = 16'h0000;
    logic        imem_req, nop_out, halt;
    logic [15:0] imem_addr, pc_out, inst_out;
`ifdef IF_FETCH_PERF_EN
    logic [15:0] fetch_cnt;
`endif
    int checks = 0, errors = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .inst_out(inst_out), .nop_out(nop_out),
`ifdef IF_FETCH_PERF_EN
        .fetch_cnt(fetch_cnt),
`endif
        .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [15:0] p, input logic [15:0] i, input logic n);
        chk({tag, "_pc"}, pc_out, p);
        chk({tag, "_inst"}, inst_out, i);
        chk({tag, "_nop"}, {15'd0, nop_out}, {15'd0, n});
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_halt", {15'd0, halt}, 16'd0);
        outs("rst", 16'h0000, 16'h0000, 1'b1);
`ifdef IF_FETCH_PERF_EN
        chk("rst_cnt", fetch_cnt, 16'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rel_req", {15'd0, imem_req}, 16'd1);
        chk("rel_addr", imem_addr, 16'h0000);
        // back-to-back acks
        imem_ack = 1'b1; imem_rdata = 16'h1111;
        cyc();
        outs("b2b0", 16'h0000, 16'h1111, 1'b0);
        imem_rdata = 16'h2222;
        cyc();
        outs("b2b1", 16'h0002, 16'h2222, 1'b0);
        chk("b2b_addr", imem_addr, 16'h0004);
        imem_ack = 1'b0;
        cyc();
        outs("idle", 16'h0002, 16'h0000, 1'b1);
        // stalled ack goes to skid
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h4321;
        cyc();
        imem_ack = 1'b0;
        outs("skid0", 16'h0002, 16'h0000, 1'b1);
        chk("skid_req", {15'd0, imem_req}, 16'd0);
        cyc();
        cyc();
        outs("skid2", 16'h0002, 16'h0000, 1'b1);
        chk("skid_req2", {15'd0, imem_req}, 16'd0);
        stall = 1'b0;
        cyc();
        outs("unskid", 16'h0004, 16'h4321, 1'b0);
        chk("unskid_addr", imem_addr, 16'h0006);
        // halt opcode
        imem_ack = 1'b1; imem_rdata = 16'hF000;
        cyc();
        imem_ack = 1'b0;
        outs("haltw", 16'h0006, 16'hF000, 1'b0);
        chk("halt_on", {15'd0, halt}, 16'd1);
        chk("halt_req", {15'd0, imem_req}, 16'd0);
        cyc();
        outs("halt_bub", 16'h0006, 16'h0000, 1'b1);
        redirect = 1'b1; redirect_pc = 16'h0040;
        cyc();
        redirect = 1'b0;
        chk("unhalt", {15'd0, halt}, 16'd0);
        chk("unhalt_req", {15'd0, imem_req}, 16'd1);
        chk("unhalt_addr", imem_addr, 16'h0040);
        // redirect with outstanding request, retargeted while killing
        redirect = 1'b1; redirect_pc = 16'h0BAD;
        cyc();
        redirect_pc = 16'h1234;
        outs("kill0", 16'h0006, 16'h0000, 1'b1);
        chk("kill_addr0", imem_addr, 16'h0040);
        cyc();
        redirect = 1'b0;
        chk("kill_addr1", imem_addr, 16'h0040);
        chk("kill_req", {15'd0, imem_req}, 16'd1);
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        cyc();
        outs("kill_drop", 16'h0006, 16'h0000, 1'b1);
        chk("kill_tgt", imem_addr, 16'h1234);
        imem_rdata = 16'h0ABC;
        cyc();
        outs("tgt", 16'h1234, 16'h0ABC, 1'b0);
`ifdef IF_FETCH_PERF_EN
        chk("perf_cnt", fetch_cnt, 16'd5);
`endif
        // redirect with same-cycle ack, then PC wrap
        redirect = 1'b1; redirect_pc = 16'hFFFE; imem_rdata = 16'h7777;
        cyc();
        redirect = 1'b0;
        outs("rdack", 16'h1234, 16'h0000, 1'b1);
        chk("rdack_addr", imem_addr, 16'hFFFE);
        imem_rdata = 16'h0111;
        cyc();
        outs("wrap0", 16'hFFFE, 16'h0111, 1'b0);
        imem_rdata = 16'h0222;
        cyc();
        outs("wrap1", 16'h0000, 16'h0222, 1'b0);
        // redirect beats stall and skid
        stall = 1'b1; imem_rdata = 16'h0333;
        cyc();
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
        cyc();
        redirect = 1'b0;
        outs("rd_skid", 16'h0000, 16'h0000, 1'b1);
        chk("rd_skid_addr", imem_addr, 16'h0100);
        chk("rd_skid_req", {15'd0, imem_req}, 16'd1);
        stall = 1'b0;
        // reset mid-request
        rst = 1'b1;
        #1;
        chk("arst_req", {15'd0, imem_req}, 16'd0);
        outs("arst", 16'h0000, 16'h0000, 1'b1);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_addr", imem_addr, 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'hF, inst[15:12] value that halts fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  downstream hazard hold; output registers frozen while 1.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; flush fetch path.
REQ-007 SHALL have port redirect_pc  input  16  target PC, sampled when redirect=1.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request.
REQ-009 SHALL have port imem_addr  output  16  request address, equal to internal PC.
REQ-010 SHALL have port imem_ack  input  1  data valid on imem_rdata this cycle; ignored when imem_req=0.
REQ-011 SHALL have port imem_rdata  input  16  fetched instruction word.
REQ-012 SHALL have port pc_out  output  16  address of instruction on inst_out; feeds IF/ID buffer pc input.
REQ-013 SHALL have port inst_out  output  16  fetched instruction; feeds IF/ID buffer instruction input.
REQ-014 SHALL have port nop_out  output  1  1 = bubble, inst_out forced 16'h0000; feeds IF/ID buffer nop input.
REQ-015 SHALL have port halt  output  1  fetch stopped on HALT_OPCODE.

Function
REQ-016 SHALL implement FSM states FETCH, SKID, KILL, HALT.
REQ-017 FETCH: imem_req=1; once asserted, imem_req and imem_addr SHALL hold until imem_ack (no abort).
REQ-018 FETCH, ack, stall=0: next edge load pc_out=PC, inst_out=imem_rdata, nop_out=0, PC+=2; stay FETCH.
REQ-019 FETCH, ack, stall=1: capture word/PC into skid register, PC+=2, go SKID; outputs unchanged.
REQ-020 SKID: imem_req=0; when stall=0, move skid to outputs (nop_out=0), go FETCH.
REQ-021 Cycle with stall=0 and no instruction delivered: next edge nop_out=1, inst_out=16'h0000, pc_out unchanged.
REQ-022 Latency: imem_ack edge to inst_out valid = 1 cycle; back-to-back single-cycle acks give one instruction per cycle.
REQ-023 PC arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.
REQ-024 redirect SHALL take priority over stall, skid and halt.
REQ-025 redirect: next edge PC=redirect_pc, skid discarded, nop_out=1, inst_out=16'h0000.
REQ-026 redirect while request outstanding with no ack same cycle: go KILL; KILL holds imem_req/imem_addr at old address, discards data at ack, then FETCH at redirect_pc.
REQ-027 redirect with ack same cycle: data discarded, go FETCH at redirect_pc directly.
REQ-028 Second redirect in KILL SHALL overwrite the pending target; last target wins.
REQ-029 Delivered word with inst[15:12]=HALT_OPCODE SHALL be output normally, then FSM goes HALT.
REQ-030 HALT: imem_req=0, halt=1, outputs bubble; exit only by redirect (to FETCH) or reset.

Reset
REQ-031 While rst=1: imem_req=0, pc_out=16'h0000, inst_out=16'h0000, nop_out=1, halt=0, PC=RESET_PC, state FETCH, skid empty.
REQ-032 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-033 rst mid-request SHALL abandon the transaction; any later ack for it is ignored since imem_req=0 during reset.

Configuration
REQ-034 Macro IF_FETCH_PERF_EN defined: extra port fetch_cnt output 16, counts instructions delivered with nop_out=0, saturates at 16'hFFFF, reset to 0.
REQ-035 IF_FETCH_PERF_EN undefined: port fetch_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 Reset release, ack every cycle, rdata 16'h1111,16'h2222 -> pc_out 0000/0002, inst_out 1111/2222 on consecutive cycles, nop_out=0.
REQ-037 Ack with stall=1 for 3 cycles, rdata 16'h4321 -> outputs frozen, imem_req=0 in SKID; 1 cycle after stall drops inst_out=4321.
REQ-038 redirect=1, redirect_pc=16'h1234, ack delayed 2 cycles -> bubble next cycle, old word discarded, next imem_addr=1234.
REQ-039 rdata 16'hF000 at PC 0006 -> inst_out=F000, pc_out=0006, then halt=1, imem_req=0; redirect to 16'h0040 resumes fetch.
REQ-040 PC preset to 16'hFFFE via redirect, two acks -> pc_out FFFE then 0000.
REQ-041 IF_FETCH_PERF_EN set, 5 deliveries with 2 bubbles and 1 redirect-killed word -> fetch_cnt=5.
